// File: rtl/mantissa_addsub_norm.sv
// Mantissa add/sub with FSM left-normalization for the FPU add path.
// Define MANTISSA_LZC_FAST_EN to replace iterative NORM with LZC + barrel shift.
module mantissa_addsub_norm #(
  parameter int WIDTH = 24,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] maior_mantissa,
  input  logic [WIDTH-1:0] menor_mantissa,
  input  logic             sinal_resultado,
  input  logic [EXP_W-1:0] exponent,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mantissa_out,
  output logic [EXP_W-1:0] exponent_out,
  output logic             sign_out,
  output logic             zero,
  output logic             overflow,
  output logic             underflow
);

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  state_t r_state, w_next;

  logic [WIDTH-1:0] r_maior, r_menor;
  logic [EXP_W-1:0] r_exp_in;
  logic             r_sgn_in, r_sub;

  logic [WIDTH-1:0] r_mant;
  logic [EXP_W-1:0] r_exp;
  logic             r_sign, r_zero, r_ovf, r_unf;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [EXP_W-1:0] w_exp_inc;
  logic             w_calc_norm;
  logic             w_norm_end;

  assign w_sum     = {1'b0, r_maior} + {1'b0, r_menor};
  assign w_diff    = r_maior - r_menor;
  assign w_exp_inc = r_exp_in + EXP_ONE;

`ifdef MANTISSA_LZC_FAST_EN
  localparam int LZW = $clog2(WIDTH + 1);
  localparam int CW  = (EXP_W > LZW) ? EXP_W : LZW;

  logic [CW-1:0] w_lz, w_emax, w_shift;

  always_comb begin
    w_lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (w_diff[i]) w_lz = CW'(WIDTH - 1 - i);
  end

  // Shift is capped so the exponent never drops below 1.
  assign w_emax      = CW'(r_exp_in) - CW'(1);
  assign w_shift     = (w_lz < w_emax) ? w_lz : w_emax;
  assign w_calc_norm = 1'b0;
`else
  assign w_calc_norm = r_sub && (w_diff != '0) &&
                       !w_diff[WIDTH-1] && (r_exp_in != '0);
`endif

  assign w_norm_end = ((r_exp == EXP_ONE) && !r_mant[WIDTH-1]) ||
                      r_mant[WIDTH-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_next = CALC;
      CALC:    w_next = w_calc_norm ? NORM : DONE;
      NORM:    if (w_norm_end) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_maior  <= '0;
      r_menor  <= '0;
      r_exp_in <= '0;
      r_sgn_in <= 1'b0;
      r_sub    <= 1'b0;
      r_mant   <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (in_valid) begin
          r_maior  <= maior_mantissa;
          r_menor  <= menor_mantissa;
          r_exp_in <= exponent;
          r_sgn_in <= sinal_resultado;
          r_sub    <= op_sub;
          r_zero   <= 1'b0;
          r_ovf    <= 1'b0;
          r_unf    <= 1'b0;
        end
        CALC: begin
          r_sign <= r_sgn_in;
          r_exp  <= r_exp_in;
          if (!r_sub) begin
            if (w_sum[WIDTH]) begin
              if (w_exp_inc == EXP_ONES) begin
                r_ovf  <= 1'b1;
                r_exp  <= EXP_ONES;
                r_mant <= '0;
              end else begin
                r_exp  <= w_exp_inc;
                r_mant <= w_sum[WIDTH:1];
              end
            end else begin
              r_mant <= w_sum[WIDTH-1:0];
              if ((r_exp_in == '0) && w_sum[WIDTH-1]) r_exp <= EXP_ONE;
            end
          end else if (w_diff == '0) begin
            r_zero <= 1'b1;
            r_mant <= '0;
            r_exp  <= '0;
            r_sign <= 1'b0;
          end else begin
            r_mant <= w_diff;
`ifdef MANTISSA_LZC_FAST_EN
            if (!w_diff[WIDTH-1] && (r_exp_in != '0)) begin
              r_mant <= w_diff << w_shift;
              if (w_shift < w_lz) begin
                r_exp <= '0;
                r_unf <= 1'b1;
              end else begin
                r_exp <= r_exp_in - w_shift[EXP_W-1:0];
              end
            end
`endif
          end
        end
        NORM: begin
          if ((r_exp == EXP_ONE) && !r_mant[WIDTH-1]) begin
            r_exp <= '0;
            r_unf <= 1'b1;
          end else begin
            r_mant <= r_mant << 1;
            r_exp  <= r_exp - EXP_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state == DONE);
  assign mantissa_out = r_mant;
  assign exponent_out = r_exp;
  assign sign_out     = r_sign;
  assign zero         = r_zero;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_mantissa_addsub_norm.sv
// Random + directed bench for mantissa_addsub_norm.
// Reference model works from leading-zero counts, not the FSM steps.
module tb_mantissa_addsub_norm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] maior_mantissa;
  logic [23:0] menor_mantissa;
  logic        sinal_resultado;
  logic [7:0]  exponent;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] mantissa_out;
  logic [7:0]  exponent_out;
  logic        sign_out;
  logic        zero;
  logic        overflow;
  logic        underflow;

  int n_chk = 0;
  int n_err = 0;

  mantissa_addsub_norm #(.WIDTH(24), .EXP_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .maior_mantissa  (maior_mantissa),
    .menor_mantissa  (menor_mantissa),
    .sinal_resultado (sinal_resultado),
    .exponent        (exponent),
    .op_sub          (op_sub),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .mantissa_out    (mantissa_out),
    .exponent_out    (exponent_out),
    .sign_out        (sign_out),
    .zero            (zero),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model(input logic [23:0] a, input logic [23:0] b,
                       input logic [7:0] e, input logic s, input logic sub,
                       output logic [23:0] m, output logic [7:0] eo,
                       output logic so, output logic z, output logic ov,
                       output logic un, output int lat);
    logic [24:0] sum;
    logic [23:0] d;
    int ei;
    int lz;
    ei  = int'(e);
    z   = 1'b0;
    ov  = 1'b0;
    un  = 1'b0;
    so  = s;
    lat = 2;
    m   = '0;
    eo  = e;
    if (!sub) begin
      sum = {1'b0, a} + {1'b0, b};
      if (sum[24]) begin
        m  = sum[24:1];
        eo = 8'(ei + 1);
        if (eo == 8'hFF) begin
          ov = 1'b1;
          m  = '0;
        end
      end else begin
        m = sum[23:0];
        if (ei == 0 && sum[23]) eo = 8'd1;
      end
    end else begin
      d = a - b;
      if (d == '0) begin
        z  = 1'b1;
        eo = '0;
        so = 1'b0;
      end else if (ei == 0) begin
        m = d;
      end else begin
        lz = 0;
        while (lz < 24 && d[23-lz] == 1'b0) lz++;
        if (lz <= ei - 1) begin
          m   = d << lz;
          eo  = 8'(ei - lz);
          lat = 2 + lz;
        end else begin
          m   = d << (ei - 1);
          eo  = '0;
          un  = 1'b1;
          lat = 2 + ei;
        end
      end
    end
`ifdef MANTISSA_LZC_FAST_EN
    lat = 2;
`endif
  endtask

  task automatic do_op(input logic [23:0] a, input logic [23:0] b,
                       input logic [7:0] e, input logic s, input logic sub,
                       input int hold, input string tag);
    logic [23:0] m;
    logic [7:0]  eo;
    logic        so, z, ov, un;
    int          lat, n;
    model(a, b, e, s, sub, m, eo, so, z, ov, un, lat);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid        = 1'b1;
    maior_mantissa  = a;
    menor_mantissa  = b;
    exponent        = e;
    sinal_resultado = s;
    op_sub          = sub;
    @(posedge clk);
    #1;
    in_valid        = 1'b0;
    maior_mantissa  = 24'($urandom);
    menor_mantissa  = 24'($urandom);
    exponent        = 8'($urandom);
    sinal_resultado = 1'($urandom);
    op_sub          = 1'($urandom);
    check({tag, "_flags_clr"}, 64'({zero, overflow, underflow}), 64'd0);
    n = 1;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_res"},
          {28'd0, mantissa_out, exponent_out, sign_out, zero, overflow,
           underflow},
          {28'd0, m, eo, so, z, ov, un});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold"},
            {27'd0, out_valid, in_ready, mantissa_out, exponent_out,
             sign_out, zero, overflow, underflow},
            {27'd0, 1'b1, 1'b0, m, eo, so, z, ov, un});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_release"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    logic [23:0] a, b;
    logic [7:0]  e;
    rst_n           = 1'b0;
    in_valid        = 1'b0;
    out_ready       = 1'b0;
    maior_mantissa  = '0;
    menor_mantissa  = '0;
    sinal_resultado = 1'b0;
    exponent        = '0;
    op_sub          = 1'b0;
    #23;
    check("reset",
          {28'd0, out_valid, in_ready, mantissa_out, exponent_out, sign_out,
           zero, overflow, underflow},
          {28'd0, 2'b01, 36'd0});
    @(negedge clk);
    rst_n = 1'b1;

    do_op(24'hC00000, 24'h800000, 8'h80, 1'b0, 1'b0, 0, "add");
    do_op(24'h800000, 24'h7FFFFF, 8'h80, 1'b0, 1'b1, 0, "deep");
    do_op(24'h912345, 24'h912345, 8'h45, 1'b1, 1'b1, 0, "cancel");
    do_op(24'hFFFFFF, 24'hFFFFFF, 8'hFE, 1'b1, 1'b0, 0, "ovf");
    do_op(24'h800000, 24'h7FFFFF, 8'h03, 1'b0, 1'b1, 0, "unf");
    do_op(24'h400000, 24'h000001, 8'h01, 1'b1, 1'b1, 0, "unf_e1");
    do_op(24'h600000, 24'h100000, 8'h00, 1'b0, 1'b1, 0, "sub_e0");
    do_op(24'h500000, 24'h400000, 8'h00, 1'b1, 1'b0, 0, "promote");
    do_op(24'hA00000, 24'h100000, 8'h10, 1'b1, 1'b1, 10, "backpr");

    // Reset while the deep subtraction is still normalizing.
    @(negedge clk);
    in_valid       = 1'b1;
    maior_mantissa = 24'h800000;
    menor_mantissa = 24'h7FFFFF;
    exponent       = 8'h80;
    op_sub         = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid",
          {28'd0, out_valid, in_ready, mantissa_out, exponent_out, sign_out,
           zero, overflow, underflow},
          {28'd0, 2'b01, 36'd0});
    @(negedge clk);
    rst_n = 1'b1;
    do_op(24'hC00000, 24'h800000, 8'h80, 1'b0, 1'b0, 0, "after_rst");

    for (int t = 0; t < 60; t++) begin
      a = 24'($urandom);
      if ($urandom_range(0, 3) != 0) a[23] = 1'b1;
      b = a - (24'($urandom) >> $urandom_range(0, 23));
      if (b > a) b = a;
      if ($urandom_range(0, 3) == 0) b = 24'($urandom) % (a + 24'd1);
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6))
                                      : 8'($urandom_range(0, 254));
      do_op(a, b, e, 1'($urandom), 1'($urandom), $urandom_range(0, 2),
            "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
